// File: rtl/mat_result_serializer.sv
// Output-side reader for the 4x4 matrix multiplier: captures one 128-bit frame of
// 16 product elements and streams it out one element per beat over valid/ready.
module mat_result_serializer #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cap_valid,
    output logic                       cap_ready,
    input  logic [ELEM_W*N_ELEM-1:0]   cap_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_data,
    output logic [$clog2(N_ELEM)-1:0]  out_index,
    output logic                       out_last,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic                       busy
);

    localparam int FRAME_W = ELEM_W * N_ELEM;
    localparam int IDX_W   = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_buf, buf_d;
    logic [ELEM_W-1:0]    data_d;
    logic [IDX_W-1:0]     idx_d;
    logic [IDX_W-1:0]     idx_next;
    logic                 last_d;
    logic                 valid_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 last_beat;
    logic                 do_load;

    assign last_beat = (state_q == SEND) & out_valid & out_ready & (out_index == LAST_IDX);
    assign cap_ready = reset & ((state_q == IDLE) | last_beat);
    assign busy      = (state_q == SEND);
    assign idx_next  = out_index + IDX_W'(1);

    // frame_buf holds the not-yet-sent elements left-aligned, so the next element is always at the top
    always_comb begin
        state_d = state_q;
        buf_d   = frame_buf;
        data_d  = out_data;
        idx_d   = out_index;
        last_d  = out_last;
        valid_d = out_valid;
        cnt_d   = frame_cnt;
        do_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    do_load = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (out_index == LAST_IDX) begin
                        cnt_d = frame_cnt + CNT_W'(1);
                        if (cap_valid) begin
                            do_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            idx_d   = '0;
                        end
                    end else begin
                        idx_d  = idx_next;
                        data_d = frame_buf[FRAME_W-1 -: ELEM_W];
                        buf_d  = frame_buf << ELEM_W;
                        last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            state_d = SEND;
            buf_d   = cap_data << ELEM_W;
            data_d  = cap_data[FRAME_W-1 -: ELEM_W];
            idx_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            frame_buf <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            frame_buf <= buf_d;
            out_data  <= data_d;
            out_index <= idx_d;
            out_last  <= last_d;
            out_valid <= valid_d;
            frame_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer: frames are queued when driven and
// every accepted output beat is popped and compared against them.
module tb_mat_result_serializer;

    logic         clk;
    logic         reset;
    logic         cap_valid;
    logic         cap_ready;
    logic [127:0] cap_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_index;
    logic         out_last;
    logic [7:0]   frame_cnt;
    logic         busy;

    int           n_compared;
    int           n_mismatched;
    logic [7:0]   exp_cnt;
    logic [12:0]  sb[$];

    mat_result_serializer #(.ELEM_W(8), .N_ELEM(16), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: a beat is transferred at the coming edge when valid & ready
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_compared++;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL beat_unexpected got idx=%0d data=%h, required no beat", out_index, out_data);
            end else begin
                logic [12:0] exp;
                exp = sb.pop_front();
                if ({out_last, out_index, out_data} !== exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL beat got last=%b idx=%0d data=%h, required last=%b idx=%0d data=%h",
                             out_last, out_index, out_data, exp[12], exp[11:8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [127:0] f);
        for (int i = 0; i < 16; i++) begin
            sb.push_back({(i == 15), 4'(i), f[127 - 8*i -: 8]});
        end
    endtask

    // Presents a frame and returns just after the edge that captured it
    task automatic do_capture(input logic [127:0] f);
        logic ok;
        ok = 1'b0;
        cap_data  = f;
        cap_valid = 1'b1;
        push_frame(f);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cap_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cap_valid = 1'b0;
        n_compared++;
        if (!ok) begin
            n_mismatched++;
            $display("[TB] FAIL capture_timeout got cap_ready=%b, required 1", cap_ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        cap_valid = 1'b1;
        cap_data  = '1;
        out_ready = 1'b1;
        tick();
        tick();
        n_compared++;
        if ({out_valid, out_data, out_index, out_last, frame_cnt, busy} !== 23'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs got v=%b d=%h i=%0d l=%b cnt=%0d busy=%b, required all 0",
                     out_valid, out_data, out_index, out_last, frame_cnt, busy);
        end
        n_compared++;
        if (cap_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_cap_ready got %b, required 0", cap_ready);
        end
        cap_valid = 1'b0;
        reset     = 1'b1;
        exp_cnt   = 8'd0;
        tick();
        n_compared++;
        if ({cap_ready, busy} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset got ready=%b busy=%b, required 1 0", cap_ready, busy);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_capture(128'h000102030405060708090A0B0C0D0E0F);
        n_compared++;
        if ({out_valid, busy, out_index, out_data} !== {1'b1, 1'b1, 4'd0, 8'h00}) begin
            n_mismatched++;
            $display("[TB] FAIL basic_first got v=%b busy=%b i=%0d d=%h, required 1 1 0 00",
                     out_valid, busy, out_index, out_data);
        end
        repeat (15) tick();
        n_compared++;
        if ({out_last, out_index, out_data} !== {1'b1, 4'd15, 8'h0F}) begin
            n_mismatched++;
            $display("[TB] FAIL basic_last got l=%b i=%0d d=%h, required 1 15 0f", out_last, out_index, out_data);
        end
        tick();
        exp_cnt++;
        n_compared++;
        if ({busy, out_valid, out_last, out_index, frame_cnt, cap_ready} !== {7'b0000000, exp_cnt, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL basic_done got busy=%b v=%b l=%b i=%0d cnt=%0d ready=%b, required 0 0 0 0 %0d 1",
                     busy, out_valid, out_last, out_index, frame_cnt, cap_ready, exp_cnt);
        end
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_drain got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b1;
        do_capture(128'h000102030405060708090A0B0C0D0E0F);
        repeat (5) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_compared++;
            if ({out_valid, out_index, out_data} !== {1'b1, 4'd5, 8'h05}) begin
                n_mismatched++;
                $display("[TB] FAIL hold_%0d got v=%b i=%0d d=%h, required 1 5 05", k, out_valid, out_index, out_data);
            end
        end
        out_ready = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        exp_cnt++;
        n_compared++;
        if (n != 11 || frame_cnt !== exp_cnt) begin
            n_mismatched++;
            $display("[TB] FAIL bp_finish got beats=%0d cnt=%0d, required 11 %0d", n, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_capture({16{8'hE1}});
        cap_data  = 128'd0;
        cap_valid = 1'b1;
        push_frame(128'd0);
        #1;
        for (int k = 0; k < 16; k++) begin
            n_compared++;
            if (cap_ready !== (k == 15)) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_ready_%0d got %b, required %b", k, cap_ready, (k == 15));
            end
            tick();
        end
        cap_valid = 1'b0;
        exp_cnt++;
        n_compared++;
        if ({out_valid, out_index, out_data, frame_cnt} !== {1'b1, 4'd0, 8'h00, exp_cnt}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_switch got v=%b i=%0d d=%h cnt=%0d, required 1 0 00 %0d",
                     out_valid, out_index, out_data, frame_cnt, exp_cnt);
        end
        repeat (16) tick();
        exp_cnt++;
        n_compared++;
        if ({busy, frame_cnt} !== {1'b0, exp_cnt}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_done got busy=%b cnt=%0d, required 0 %0d", busy, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_early_cap();
        logic [127:0] fy;
        fy = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
        out_ready = 1'b1;
        do_capture(128'h102132435465768798A9BACBDCEDFE0F);
        repeat (3) tick();
        cap_data  = fy;
        cap_valid = 1'b1;
        push_frame(fy);
        #1;
        for (int k = 3; k < 15; k++) begin
            n_compared++;
            if ({cap_ready, out_index} !== {1'b0, 4'(k)}) begin
                n_mismatched++;
                $display("[TB] FAIL early_ready_%0d got ready=%b i=%0d, required 0 %0d", k, cap_ready, out_index, k);
            end
            tick();
        end
        n_compared++;
        if (cap_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL early_last_ready got %b, required 1", cap_ready);
        end
        tick();
        cap_valid = 1'b0;
        exp_cnt++;
        n_compared++;
        if ({out_index, out_data} !== {4'd0, 8'hF0}) begin
            n_mismatched++;
            $display("[TB] FAIL early_new_frame got i=%0d d=%h, required 0 f0", out_index, out_data);
        end
        repeat (16) tick();
        exp_cnt++;
        n_compared++;
        if ({busy, frame_cnt} !== {1'b0, exp_cnt}) begin
            n_mismatched++;
            $display("[TB] FAIL early_done got busy=%b cnt=%0d, required 0 %0d", busy, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_capture(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
        repeat (7) tick();
        n_compared++;
        if (out_index !== 4'd7) begin
            n_mismatched++;
            $display("[TB] FAIL mid_index got %0d, required 7", out_index);
        end
        reset = 1'b0;
        tick();
        n_compared++;
        if ({out_valid, out_index, frame_cnt, busy, cap_ready} !== 15'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset got v=%b i=%0d cnt=%0d busy=%b ready=%b, required all 0",
                     out_valid, out_index, frame_cnt, busy, cap_ready);
        end
        reset   = 1'b1;
        exp_cnt = 8'd0;
        sb.delete();
        do_capture(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        n_compared++;
        if ({out_valid, out_index, out_data} !== {1'b1, 4'd0, 8'hA0}) begin
            n_mismatched++;
            $display("[TB] FAIL mid_restart got v=%b i=%0d d=%h, required 1 0 a0", out_valid, out_index, out_data);
        end
        repeat (16) tick();
        exp_cnt++;
        n_compared++;
        if ({busy, frame_cnt} !== {1'b0, exp_cnt}) begin
            n_mismatched++;
            $display("[TB] FAIL mid_done got busy=%b cnt=%0d, required 0 %0d", busy, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        exp_cnt   = 8'd0;
        out_ready = 1'b1;
        cap_data  = '1;
        cap_valid = 1'b1;
        for (int f = 0; f < 256; f++) push_frame('1);
        tick();
        for (int f = 1; f <= 256; f++) begin
            repeat (16) tick();
            if (f == 255) cap_valid = 1'b0;
            exp_cnt++;
            n_compared++;
            if (frame_cnt !== exp_cnt) begin
                n_mismatched++;
                $display("[TB] FAIL wrap_cnt_%0d got %0d, required %0d", f, frame_cnt, exp_cnt);
            end
        end
        n_compared++;
        if ({busy, out_valid, frame_cnt} !== 10'd0) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_done got busy=%b v=%b cnt=%0d, required 0 0 0", busy, out_valid, frame_cnt);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        exp_cnt      = 8'd0;
        reset        = 1'b0;
        cap_valid    = 1'b0;
        cap_data     = '0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_early_cap();
        test_reset_mid();
        test_wrap();
        tick();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL final_drain got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mat_result_serializer.md
Name: mat_result_serializer

Overview:
- Output-side reader for the 4x4 matrix multiplier.
- Captures the 16 parallel 8-bit product elements (q..f2, row-major C00..C33) as one 128-bit frame.
- Streams the frame out one element per beat over a valid/ready handshake, with element index and last flag.
- Decouples the combinational multiplier from a narrow downstream consumer such as a UART or memory writer.

Parameters:
ELEM_W, 8, width of one product element (fixed to 8 for the 4x4 multiplier of 4-bit operands)
N_ELEM, 16, elements per frame (fixed; 4x4 matrix)
CNT_W, 8, width of completed-frame counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
cap_valid  input  1  frame available on cap_data
cap_ready  output  1  serializer can accept a frame this cycle
cap_data  input  128  frame; element 0 (C00/q) at [127:120] ... element 15 (C33/f2) at [7:0]
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts element this cycle
out_data  output  8  current element
out_index  output  4  index 0..15 of out_data (row = index[3:2], col = index[1:0])
out_last  output  1  high with element 15
frame_cnt  output  CNT_W  count of fully transmitted frames, wraps
busy  output  1  high in SEND state

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; out_valid=0, out_data=0, out_index=0, out_last=0, frame_cnt=0, busy=0, frame buffer cleared. cap_ready is forced 0 while reset is low.
- Reset mid-frame aborts the frame. Remaining elements are discarded and frame_cnt does not increment.
- Capture handshake occurs when cap_valid & cap_ready at a clk edge. cap_data is ignored otherwise.
- cap_ready is combinational:
  - 1 in IDLE.
  - 1 in SEND only when out_index==15 & out_valid & out_ready (last-beat handoff).
  - 0 otherwise.
- State IDLE:
  - On capture: load buffer, out_index=0, out_data=element 0, out_valid=1, busy=1, go to SEND.
  - Latency: first element is valid the cycle after the capture edge.
- State SEND:
  - out_valid=1 continuously.
  - Output hold: while out_valid & !out_ready, out_data, out_index and out_last are held stable.
  - On an out handshake with out_index<15: out_index+1; out_data = next element; out_last=(new index==15).
  - On the out handshake with out_index==15: frame_cnt+1, wrapping 2^CNT_W-1 -> 0.
    - If cap_valid is also high in that cycle (back-to-back), load the new frame; out_index=0; stay in SEND. No bubble cycle.
    - Else: out_valid=0, out_last=0, out_index=0, busy=0, go to IDLE. out_data holds its last value.
- Throughput: one element per cycle with out_ready held high. 16 cycles per frame; back-to-back frames are gapless.
- A cap_valid high in SEND before the last beat is not accepted. The producer must hold cap_valid and cap_data until cap_ready.
- out_ready is don't-care while out_valid=0.
- Width: elements pass through unmodified (8-bit in, 8-bit out); no arithmetic on data.

Test Plan:
- Basic frame: after reset release, cap_data=128'h000102030405060708090A0B0C0D0E0F, cap_valid for 1 cycle, out_ready=1.
  -> out_data 00..0F on 16 consecutive cycles starting 1 cycle after capture; out_index 0..15; out_last only on 0F; frame_cnt=1; busy drops after the last beat; cap_ready=1 again.
- Backpressure: same frame; out_ready=0 for 3 cycles while out_index=5.
  -> out_data=05 and out_index=5 held for those 3 cycles, no element skipped or duplicated; frame completes 3 cycles later than the basic frame.
- Back-to-back: frame A (all 8'hE1) then frame B (all 8'h00), with cap_valid held high.
  -> cap_ready pulses only on A's last beat; B's element 0 appears the cycle after A's element 15 with no gap; frame_cnt=2.
- Reset mid-frame: assert reset=0 for 1 cycle at out_index=7.
  -> next cycle out_valid=0, out_index=0, frame_cnt=0, busy=0.
  -> a new capture afterwards streams from element 0.
- Counter wrap: stream 256 frames of 128'hFF..FF.
  -> every out_data=FF; frame_cnt reads 255 after frame 255 and 0 after frame 256.
- Early cap_valid: assert cap_valid at out_index=3 with a different frame.
  -> cap_ready=0, current frame unaltered; new frame captured exactly at the last-beat handshake.
